// File: rtl/synthesijer_fp_pkg.sv
// Shared floating-point helpers: operand classes, field-position helpers, canonical qNaN.
package synthesijer_fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  // Widest format the qNaN helper can describe; callers slice to their own width.
  localparam int unsigned FpMaxW = 128;

  function automatic int unsigned fp_width(input int unsigned exp_w, input int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int unsigned fp_sign_pos(input int unsigned exp_w, input int unsigned man_w);
    return exp_w + man_w;
  endfunction

  // Sign 0, exponent all-ones, fraction MSB set, remaining fraction bits clear.
  function automatic logic [FpMaxW-1:0] fp_qnan(input int unsigned exp_w,
                                                input int unsigned man_w);
    logic [FpMaxW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < exp_w; i++) begin
      r[man_w + i] = 1'b1;
    end
    r[man_w - 1] = 1'b1;
    return r;
  endfunction

  // Denormals classify as zero: they are flushed before use.
  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_zero);
    if (exp_zero) begin
      return FP_ZERO;
    end
    if (!exp_ones) begin
      return FP_NORM;
    end
    return frac_zero ? FP_INF : FP_NAN;
  endfunction

endpackage

// File: rtl/synthesijer_fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields N.
module synthesijer_fp_lzc #(
  parameter int unsigned N = 56,
  localparam int unsigned CntW = $clog2(N + 1)
) (
  input  logic [N-1:0]    in_i,
  output logic [CntW-1:0] cnt_o
);

  logic found;

  // Scan from the MSB; the first set bit fixes the count.
  always_comb begin
    cnt_o = CntW'(N);
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && in_i[i]) begin
        cnt_o = CntW'(N - 1 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/synthesijer_fadd_pipe.sv
// Five-stage IEEE-754 adder/subtractor with flush-to-zero and round-to-nearest-even.
module synthesijer_fadd_pipe
  import synthesijer_fp_pkg::*;
#(
  parameter int unsigned EXP_W = 11,
  parameter int unsigned MAN_W = 52,
  parameter int unsigned LAT   = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  input  logic                   nd,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   valid
);

  localparam int unsigned Width   = fp_width(EXP_W, MAN_W);
  localparam int unsigned SignPos = fp_sign_pos(EXP_W, MAN_W);
  localparam int unsigned MagW    = MAN_W + 4;  // hidden + fraction + guard/round/sticky
  localparam int unsigned LzW     = $clog2(MagW + 1);
  localparam int unsigned Ew1     = EXP_W + 1;
  localparam int unsigned Ew2     = EXP_W + 2;
  localparam logic [EXP_W-1:0]  ExpOnes  = {EXP_W{1'b1}};
  localparam logic [FpMaxW-1:0] QNaNWide = fp_qnan(EXP_W, MAN_W);
  localparam logic [Width-1:0]  QNaN     = QNaNWide[Width-1:0];

  // The scheduler relies on a fixed latency; the datapath below has exactly five registers.
  if (LAT != 5) begin : g_lat_check
    $error("synthesijer_fadd_pipe: LAT must be 5");
  end

  logic [3:0] vld_q;
  logic       valid_q;

  // ---------------- Stage 1: unpack, classify, swap, resolve specials ----------------
  logic             sa, sb, swap;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fp_class_e        ca, cb;

  assign sa = a[SignPos];
  assign ea = a[SignPos-1:MAN_W];
  assign fa = a[MAN_W-1:0];
  assign sb = b[SignPos] ^ sub;
  assign eb = b[SignPos-1:MAN_W];
  assign fb = b[MAN_W-1:0];
  assign ca = fp_classify(ea == '0, ea == ExpOnes, fa == '0);
  assign cb = fp_classify(eb == '0, eb == ExpOnes, fb == '0);

  logic             sp1_d, sp1_q, sx1_d, sx1_q, sub1_d, sub1_q;
  logic [Width-1:0] spr1_d, spr1_q;
  logic [EXP_W-1:0] ex1_d, ex1_q, d1_d, d1_q;
  logic [MAN_W:0]   mx1_d, mx1_q, my1_d, my1_q;

  // Order operands by magnitude and short-circuit everything that is not normal+normal.
  always_comb begin
    swap   = {eb, fb} > {ea, fa};
    sx1_d  = swap ? sb : sa;
    ex1_d  = swap ? eb : ea;
    mx1_d  = {1'b1, swap ? fb : fa};
    my1_d  = {1'b1, swap ? fa : fb};
    d1_d   = swap ? (eb - ea) : (ea - eb);
    sub1_d = sa ^ sb;
    sp1_d  = 1'b1;
    spr1_d = '0;
    if (ca == FP_NAN || cb == FP_NAN) begin
      spr1_d = QNaN;
    end else if (ca == FP_INF && cb == FP_INF) begin
      spr1_d = (sa != sb) ? QNaN : {sa, ExpOnes, {MAN_W{1'b0}}};
    end else if (ca == FP_INF) begin
      spr1_d = {sa, ExpOnes, {MAN_W{1'b0}}};
    end else if (cb == FP_INF) begin
      spr1_d = {sb, ExpOnes, {MAN_W{1'b0}}};
    end else if (ca == FP_ZERO && cb == FP_ZERO) begin
      spr1_d = {sa & sb, {(EXP_W + MAN_W){1'b0}}};
    end else if (ca == FP_ZERO) begin
      spr1_d = {sb, eb, fb};
    end else if (cb == FP_ZERO) begin
      spr1_d = {sa, ea, fa};
    end else begin
      sp1_d = 1'b0;
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp1_q <= 1'b0; spr1_q <= '0; sx1_q <= 1'b0; sub1_q <= 1'b0;
      ex1_q <= '0;   d1_q   <= '0; mx1_q <= '0;   my1_q  <= '0;
    end else begin
      sp1_q <= sp1_d; spr1_q <= spr1_d; sx1_q <= sx1_d; sub1_q <= sub1_d;
      ex1_q <= ex1_d; d1_q   <= d1_d;   mx1_q <= mx1_d; my1_q  <= my1_d;
    end
  end

  // ---------------- Stage 2: align the smaller operand ----------------
  logic [2*MagW-1:0] sh2;
  logic [MagW-1:0]   my2_d, my2_q, mx2_q;
  logic              sp2_q, sx2_q, sub2_q;
  logic [Width-1:0]  spr2_q;
  logic [EXP_W-1:0]  ex2_q;

  // Right shift with everything shifted out folded into the sticky LSB.
  always_comb begin
    sh2 = {my1_q, 3'b000, {MagW{1'b0}}} >> d1_q;
    if (32'(d1_q) >= 32'(MAN_W + 3)) begin
      my2_d = {{(MagW - 1){1'b0}}, 1'b1};
    end else begin
      my2_d = {sh2[2*MagW-1:MagW+1], sh2[MagW] | (|sh2[MagW-1:0])};
    end
  end

  // Stage 2 register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp2_q <= 1'b0; spr2_q <= '0; sx2_q <= 1'b0; sub2_q <= 1'b0;
      ex2_q <= '0;   mx2_q  <= '0; my2_q <= '0;
    end else begin
      sp2_q <= sp1_q; spr2_q <= spr1_q; sx2_q <= sx1_q; sub2_q <= sub1_q;
      ex2_q <= ex1_q; mx2_q  <= {mx1_q, 3'b000}; my2_q <= my2_d;
    end
  end

  // ---------------- Stage 3: magnitude add/subtract ----------------
  logic [MagW:0]    sum3_d, sum3_q;
  logic             sp3_q, sx3_q;
  logic [Width-1:0] spr3_q;
  logic [EXP_W-1:0] ex3_q;

  // |x| >= |y| after the swap, so the difference never goes negative.
  always_comb begin
    sum3_d = sub2_q ? ({1'b0, mx2_q} - {1'b0, my2_q}) : ({1'b0, mx2_q} + {1'b0, my2_q});
  end

  // Stage 3 register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp3_q <= 1'b0; spr3_q <= '0; sx3_q <= 1'b0; ex3_q <= '0; sum3_q <= '0;
    end else begin
      sp3_q <= sp2_q; spr3_q <= spr2_q; sx3_q <= sx2_q; ex3_q <= ex2_q; sum3_q <= sum3_d;
    end
  end

  // ---------------- Stage 4: normalise ----------------
  logic [LzW-1:0]   lz4;
  logic [Ew2-1:0]   esh4;
  logic             sp4_d, sp4_q, s4_q;
  logic [Width-1:0] spr4_d, spr4_q;
  logic [Ew1-1:0]   e4_d, e4_q;
  logic [MagW-1:0]  m4_d, m4_q;

  synthesijer_fp_lzc #(
    .N (MagW)
  ) u_lzc (
    .in_i  (sum3_q[MagW-1:0]),
    .cnt_o (lz4)
  );

  // Carry shifts right once; otherwise shift out leading zeros, flushing on exponent underflow.
  always_comb begin
    sp4_d  = sp3_q;
    spr4_d = spr3_q;
    e4_d   = '0;
    m4_d   = '0;
    esh4   = {2'b00, ex3_q} - {{(Ew2 - LzW){1'b0}}, lz4};
    if (!sp3_q) begin
      if (sum3_q[MagW]) begin
        m4_d = {sum3_q[MagW:2], sum3_q[1] | sum3_q[0]};
        e4_d = {1'b0, ex3_q} + Ew1'(1);
      end else if (sum3_q == '0) begin
        // Exact cancellation of opposite-sign operands rounds to +0.
        sp4_d  = 1'b1;
        spr4_d = '0;
      end else if (esh4[Ew2-1] || esh4 == '0) begin
        sp4_d  = 1'b1;
        spr4_d = {sx3_q, {(Width - 1){1'b0}}};
      end else begin
        m4_d = sum3_q[MagW-1:0] << lz4;
        e4_d = esh4[Ew1-1:0];
      end
    end
  end

  // Stage 4 register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp4_q <= 1'b0; spr4_q <= '0; s4_q <= 1'b0; e4_q <= '0; m4_q <= '0;
    end else begin
      sp4_q <= sp4_d; spr4_q <= spr4_d; s4_q <= sx3_q; e4_q <= e4_d; m4_q <= m4_d;
    end
  end

  // ---------------- Stage 5: round to nearest even, pack ----------------
  logic             rnd5;
  logic [MAN_W+1:0] mr5;
  logic [Ew1-1:0]   e5;
  logic [MAN_W-1:0] frac5;
  logic [Width-1:0] res5_d, result_q;

  // Rounding carry leaves the fraction all-zero and bumps the exponent.
  always_comb begin
    rnd5  = m4_q[2] & (m4_q[3] | m4_q[1] | m4_q[0]);
    mr5   = {1'b0, m4_q[MagW-1:3]} + {{(MAN_W + 1){1'b0}}, rnd5};
    e5    = mr5[MAN_W+1] ? (e4_q + Ew1'(1)) : e4_q;
    frac5 = mr5[MAN_W+1] ? '0 : mr5[MAN_W-1:0];
    if (sp4_q) begin
      res5_d = spr4_q;
    end else if (e5 >= {1'b0, ExpOnes}) begin
      res5_d = {s4_q, ExpOnes, {MAN_W{1'b0}}};
    end else begin
      res5_d = {s4_q, e5[EXP_W-1:0], frac5};
    end
  end

  // Valid pipeline and output register; result holds while no operation completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      vld_q   <= {vld_q[2:0], nd};
      valid_q <= vld_q[3];
      if (vld_q[3]) begin
        result_q <= res5_d;
      end
    end
  end

  assign result = result_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_synthesijer_fadd_pipe.sv
// Randomised and directed checks of the fp64 and fp32 adder against a real-arithmetic model.
module tb_synthesijer_fadd_pipe;

  localparam logic [63:0] QNAN64 = 64'h7FF8000000000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] a, b, result;
  logic        sub, nd, valid;
  logic [31:0] a32, b32, result32;
  logic        sub32, nd32, valid32;

  always #5 clk = ~clk;

  synthesijer_fadd_pipe #(
    .EXP_W (11),
    .MAN_W (52)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .a      (a),
    .b      (b),
    .sub    (sub),
    .nd     (nd),
    .result (result),
    .valid  (valid)
  );

  synthesijer_fadd_pipe #(
    .EXP_W (8),
    .MAN_W (23)
  ) dut32 (
    .clk    (clk),
    .reset  (reset),
    .a      (a32),
    .b      (b32),
    .sub    (sub32),
    .nd     (nd32),
    .result (result32),
    .valid  (valid32)
  );

  typedef struct {
    int          due;
    logic [63:0] val;
  } exp_t;

  exp_t pend[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // IEEE double arithmetic with the block's flush-to-zero and canonical-NaN rules on top.
  function automatic logic [63:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic s);
    logic [63:0] r;
    real         rr;
    if ((x[62:52] == 11'h7FF && x[51:0] != 0) || (y[62:52] == 11'h7FF && y[51:0] != 0)) begin
      return QNAN64;
    end
    if (x[62:52] == 0) x = {x[63], 63'b0};
    if (y[62:52] == 0) y = {y[63], 63'b0};
    if (s) y[63] = ~y[63];
    rr = $bitstoreal(x) + $bitstoreal(y);
    r  = $realtobits(rr);
    if (r[62:52] == 11'h7FF && r[51:0] != 0) return QNAN64;
    if (r[62:52] == 0) return {r[63], 63'b0};
    return r;
  endfunction

  function automatic logic [63:0] rand_op(input bit specials);
    logic [31:0] hi, lo;
    logic [10:0] e;
    int          sel;
    hi  = $urandom;
    lo  = $urandom;
    e   = 11'(960 + $urandom_range(0, 120));
    sel = specials ? $urandom_range(0, 15) : 15;
    case (sel)
      0:       return {hi[31], 63'h7FF0000000000000};
      1:       return {hi[31], 63'h0};
      2:       return {hi[31], 63'h000F000012340000};
      3:       return {hi[31], 63'h7FF0000000001000};
      default: return {hi[31], e, hi[19:0], lo};
    endcase
  endfunction

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      check_eq("valid", {63'b0, valid}, 64'd1);
      check_eq("result", result, pend[0].val);
      pend.delete(0);
    end else begin
      check_eq("valid_idle", {63'b0, valid}, 64'd0);
    end
  endtask

  task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic s,
                       input logic [63:0] exp);
    a   = x;
    b   = y;
    sub = s;
    nd  = 1'b1;
    pend.push_back('{due: cyc + 5, val: exp});
    tick();
  endtask

  task automatic issue_rand(input bit specials);
    logic [63:0] x, y, m;
    logic        s;
    x = rand_op(specials);
    if ($urandom_range(0, 3) == 0) begin
      // Same exponent, nearby fraction: exercises deep cancellation.
      m = {32'b0, $urandom} >> $urandom_range(0, 31);
      y = {1'($urandom), x[62:52], x[51:0] ^ m[51:0]};
    end else begin
      y = rand_op(specials);
    end
    s = 1'($urandom);
    issue(x, y, s, ref_add(x, y, s));
  endtask

  task automatic idle(input int n);
    nd = 1'b0;
    repeat (n) tick();
  endtask

  task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic s,
                       input logic [31:0] exp, input string tag);
    a32   = x;
    b32   = y;
    sub32 = s;
    nd32  = 1'b1;
    tick();
    nd32  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) begin
        check_eq({tag, "_early"}, {63'b0, valid32}, 64'd0);
      end else begin
        check_eq({tag, "_valid"}, {63'b0, valid32}, 64'd1);
        check_eq(tag, {32'b0, result32}, {32'b0, exp});
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    a = '0; b = '0; sub = 1'b0; nd = 1'b0;
    a32 = '0; b32 = '0; sub32 = 1'b0; nd32 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", {63'b0, valid}, 64'd0);
    check_eq("rst_result", result, 64'd0);
    check_eq("rst_valid32", {63'b0, valid32}, 64'd0);
    check_eq("rst_result32", {32'b0, result32}, 64'd0);
    reset = 1'b1;
    idle(3);

    // Isolated op: valid must appear exactly five cycles later and nowhere else.
    issue(64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000);
    idle(7);
    issue(64'h3FF0000000000000, 64'h4000000000000000, 1'b1, 64'hBFF0000000000000);
    issue(64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000000);
    issue(64'h3FF0000000000001, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000002);
    issue(64'h7FF0000000000000, 64'hFFF0000000000000, 1'b0, QNAN64);
    issue(64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 64'h7FF0000000000000);
    issue(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 64'h0000000000000000);
    issue(64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h8000000000000000);
    issue(64'h0000000000000001, 64'h0000000000000000, 1'b0, 64'h0000000000000000);
    issue(64'h0000000000000000, 64'h8000000000000000, 1'b0, 64'h0000000000000000);
    issue(64'hC000000000000000, 64'h7FF0000000000000, 1'b1, 64'hFFF0000000000000);
    idle(7);

    // Back-to-back random normals, then straight into the reset-interrupted stream.
    for (int i = 0; i < 16; i++) issue_rand(1'b0);
    for (int i = 0; i < 8; i++) begin
      issue_rand(1'b0);
      if (i == 2) begin
        #2 reset = 1'b0;
        #1;
        check_eq("midrst_valid", {63'b0, valid}, 64'd0);
        check_eq("midrst_result", result, 64'd0);
        pend.delete();
        #2 reset = 1'b1;
      end
    end
    idle(7);

    // Random traffic with gaps and special operands.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      issue_rand(1'b1);
    end
    idle(8);
    check_eq("drain", 64'(pend.size()), 64'd0);

    run32(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, "fp32_add");
    run32(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, "fp32_nan");
    run32(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, "fp32_sub");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/synthesijer_fadd_pipe.md
Name: synthesijer_fadd_pipe

Overview:
Native, fully pipelined IEEE-754 floating-point adder/subtractor, parametrised in exponent and mantissa width. It replaces vendor-IP fadd wrappers for the fp32/fp64 operators emitted by the HLS back end. It keeps the existing nd/valid operator contract, so the scheduler treats it as a fixed-latency unit. It adds a per-operation subtract mode.

Parameters:
EXP_W, 11, exponent field width (8 for fp32)
MAN_W, 52, stored fraction width (23 for fp32)
LAT, 5, pipeline latency in cycles; fixed, not user-tunable (localparam-checked == 5)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
a  in  1+EXP_W+MAN_W  operand A
b  in  1+EXP_W+MAN_W  operand B
sub  in  1  1: compute a-b; 0: a+b; sampled with nd
nd  in  1  new data; a, b, sub sampled when high
result  out  1+EXP_W+MAN_W  sum/difference
valid  out  1  result is valid this cycle

Behaviour:
- Reset (reset=0, async assert, sync release): valid=0, result=0, all stage valid bits 0; in-flight operations are discarded. Valid stays 0 until LAT cycles after the first nd sampled after release.
- Throughput: one operation per cycle, no backpressure, no stall. valid(t+LAT) = nd(t). result holds its last value when valid=0.
- Stage 1, unpack/classify:
  - Apply sub by flipping b's sign.
  - Denormal inputs are flushed to signed zero.
  - Classify each operand as zero/normal/inf/NaN.
  - Swap so |x| >= |y| (compare exp, then fraction).
- Stage 2, align: shift y's mantissa (hidden bit restored) right by the exp difference. Guard, round and sticky bits are kept; shifts >= MAN_W+3 collapse to sticky only.
- Stage 3, add: effective add or subtract on MAN_W+4-bit magnitudes; carry-out retained.
- Stage 4, normalise:
  - On carry, shift right 1 with exp+1 and sticky preserved.
  - Otherwise left-shift by leading-zero count, exp reduced accordingly.
  - An exp underflow (<=0) flushes to signed zero.
- Stage 5, round/pack: round-to-nearest-even. Rounding carry may increment exp. Exp reaching all-ones produces ±inf. result is registered.
- Special cases, resolved in stage 1 and carried as a flag:
  - Any NaN input gives canonical qNaN: sign 0, exp all-ones, fraction MSB 1, rest 0.
  - inf + (-inf) gives qNaN.
  - inf + finite gives that inf.
  - An exact-zero result of opposite-sign operands gives +0.
  - (-0)+(-0) gives -0; (+0)+(-0) gives +0.
- No exception flags are output; overflow and underflow are silent per the rules above.

Decomposition:
- Package synthesijer_fp_pkg holds:
  - class encoding constants (FP_ZERO, FP_NORM, FP_INF, FP_NAN);
  - a width-derived localparam helper for field positions;
  - a canonical-qNaN constant function parametrised by EXP_W/MAN_W.
- One sub-module: synthesijer_fp_lzc, a parametrised combinational leading-zero counter (input width N, output clog2(N+1)) used in stage 4.
- Everything else stays in synthesijer_fadd_pipe.

Test Plan:
- fp64, a=0x3FF0000000000000, b=0x4000000000000000, sub=0, nd pulse at t → valid=1 only at t+5, result=0x4008000000000000; same operands with sub=1 → 0xBFF0000000000000.
- fp64 tie rounding: a=0x3FF0000000000000 + b=0x3CA0000000000000 → 0x3FF0000000000000 (tie to even, down). a=0x3FF0000000000001 + same b → 0x3FF0000000000002 (tie, up).
- Specials, fp64:
  - 0x7FF0000000000000 + 0xFFF0000000000000 → 0x7FF8000000000000.
  - 0x7FEFFFFFFFFFFFFF + 0x7FEFFFFFFFFFFFFF → 0x7FF0000000000000.
  - 1.0 - 1.0 (sub=1) → 0x0000000000000000.
  - 0x8000000000000000 + 0x8000000000000000 → 0x8000000000000000.
  - denormal 0x0000000000000001 + 0 → 0x0000000000000000.
- Streaming: nd high 16 consecutive cycles with random normal operands → 16 consecutive valid cycles starting 5 cycles later; results in order, bit-exact vs reference model.
- Reset mid-stream: nd high 8 cycles, assert reset low for 1 cycle at cycle 3 (between clock edges) → valid drops to 0 immediately. No valid result emerges from any operation issued before the reset. First valid arrives 5 cycles after the first post-release nd.
- fp32 instance (EXP_W=8, MAN_W=23): 0x3F800000 + 0x40000000 → 0x40400000 at t+5; 0x7FC00001 + 0x3F800000 → 0x7FC00000.
